// File: rtl/i2c_slave.sv
// i2c_slave -- I2C target exposing a SIZE-byte RAM behind an 8-bit pointer.
//   Write frame: S, {DEV_ADDR,0}, pointer, data, data, ... P
//   Read frame : S, {DEV_ADDR,1}, data, data, ... P  (reads start at the
//                pointer left by the previous transaction)
// Ports:
//   clk      system clock (must be at least 8x the sclk rate)
//   rst_n    asynchronous active-low reset
//   sclk     I2C clock from the master (asynchronous to clk)
//   sda      open-drain I2C data, driven only to 0
//   wr_ready one-clk pulse per data byte written to RAM
//   wr_addr  RAM address of that write
//   wr_data  byte of that write
//   rd_ready one-clk pulse when the master ACKs/NACKs a read byte
//   busy     high from an addressed START until STOP
// Build option: define I2C_SLAVE_ADDR_WRAP_EN to wrap the pointer from
// SIZE-1 to 0. Without it the pointer saturates at SIZE, writes beyond
// the RAM are NACKed and reads beyond it return 8'hFF. SIZE must be <= 255.
module i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         SIZE     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  inout  wire        sda,
  output logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_ready,
  output logic       busy
);
  localparam int         AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [8:0] SIZE_L = 9'(SIZE);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV_ADDR = 4'd1,
    ST_DEV_ACK  = 4'd2,
    ST_REG_ADDR = 4'd3,
    ST_REG_ACK  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_t;

  state_t     state;
  logic [7:0] ram [0:SIZE-1];
  logic [7:0] pointer;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;      // receive history, or remaining transmit bits
  logic       sda_low;
  logic       ack_en;     // value to drive during our ACK clock
  logic       ack_seen;   // ACK clock half-way flag / master ACK seen
  logic       rw;
  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       sda_meta, sda_sync, sda_prev;
  logic       sclk_rise, sclk_fall, start_det, stop_det;
  logic       in_range, ram_we;
  logic [7:0] rx_byte, rd_byte;

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Next pointer value after an access
  function automatic logic [7:0] ptr_inc(input logic [7:0] p);
`ifdef I2C_SLAVE_ADDR_WRAP_EN
    if ({1'b0, p} >= SIZE_L - 9'd1) ptr_inc = 8'd0;
    else ptr_inc = p + 8'd1;
`else
    if ({1'b0, p} >= SIZE_L - 9'd1) ptr_inc = SIZE_L[7:0];
    else ptr_inc = p + 8'd1;
`endif
  endfunction

  // Two-flop synchronizers plus one history flop for edge detection;
  // reset to the idle-bus level so release never fakes a START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta <= 1'b1; sclk_sync <= 1'b1; sclk_prev <= 1'b1;
      sda_meta  <= 1'b1; sda_sync  <= 1'b1; sda_prev  <= 1'b1;
    end else begin
      sclk_meta <= sclk; sclk_sync <= sclk_meta; sclk_prev <= sclk_sync;
      sda_meta  <= sda;  sda_sync  <= sda_meta;  sda_prev  <= sda_sync;
    end
  end

  // Bus event decode and RAM-side combinational helpers
  always_comb begin
    sclk_rise = sclk_sync & ~sclk_prev;
    sclk_fall = ~sclk_sync & sclk_prev;
    start_det = sclk_sync & sclk_prev & sda_prev & ~sda_sync;
    stop_det  = sclk_sync & sclk_prev & ~sda_prev & sda_sync;
    rx_byte   = {shreg, sda_sync};
    in_range  = ({1'b0, pointer} < SIZE_L);
    if (in_range) rd_byte = ram[pointer[AW-1:0]];
    else rd_byte = 8'hFF;
    ram_we = (state == ST_WR_DATA) && sclk_rise && (bit_cnt == 3'd7) && in_range;
  end

  // RAM write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[pointer[AW-1:0]] <= rx_byte;
  end

  // Protocol FSM with registered sda drive and strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sda_low  <= 1'b0;
      wr_ready <= 1'b0;
      rd_ready <= 1'b0;
      busy     <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      pointer  <= 8'h00;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      ack_en   <= 1'b0;
      ack_seen <= 1'b0;
      rw       <= 1'b0;
    end else begin
      wr_ready <= 1'b0;
      rd_ready <= 1'b0;
      if (start_det) begin
        state    <= ST_DEV_ADDR;
        bit_cnt  <= 3'd0;
        sda_low  <= 1'b0;
        ack_seen <= 1'b0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        sda_low  <= 1'b0;
        busy     <= 1'b0;
        ack_seen <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: sda_low <= 1'b0;
          ST_DEV_ADDR: begin
            if (sclk_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state  <= ST_DEV_ACK;
                  rw     <= rx_byte[0];
                  busy   <= 1'b1;
                  ack_en <= 1'b1;
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end
          ST_REG_ADDR: begin
            if (sclk_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                pointer <= rx_byte;
                ack_en  <= 1'b1;
                state   <= ST_REG_ACK;
              end
            end
          end
          ST_WR_DATA: begin
            if (sclk_rise) begin
              shreg   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state  <= ST_WR_ACK;
                ack_en <= in_range;
                if (in_range) begin
                  wr_ready <= 1'b1;
                  wr_addr  <= pointer;
                  wr_data  <= rx_byte;
                  pointer  <= ptr_inc(pointer);
                end
              end
            end
          end
          // First fall after the 8th bit drives the ACK, second fall ends it
          ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
            if (sclk_fall) begin
              if (!ack_seen) begin
                sda_low  <= ack_en;
                ack_seen <= 1'b1;
              end else begin
                ack_seen <= 1'b0;
                sda_low  <= 1'b0;
                if (state == ST_DEV_ACK && rw) begin
                  state   <= ST_RD_DATA;
                  shreg   <= rd_byte[6:0];
                  sda_low <= ~rd_byte[7];
                end else if (state == ST_DEV_ACK) begin
                  state <= ST_REG_ADDR;
                end else begin
                  state <= ST_WR_DATA;
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_RD_ACK;
            end else if (sclk_fall) begin
              shreg   <= {shreg[5:0], 1'b0};
              sda_low <= ~shreg[6];
            end
          end
          // Fall 1 releases sda, the rise samples the master, fall 2 sends MSB
          ST_RD_ACK: begin
            if (sclk_rise) begin
              rd_ready <= 1'b1;
              if (!sda_sync) begin
                pointer  <= ptr_inc(pointer);
                ack_seen <= 1'b1;
              end else begin
                state   <= ST_IGNORE;
                sda_low <= 1'b0;
              end
            end else if (sclk_fall) begin
              if (ack_seen) begin
                ack_seen <= 1'b0;
                state    <= ST_RD_DATA;
                shreg    <= rd_byte[6:0];
                sda_low  <= ~rd_byte[7];
              end else begin
                sda_low <= 1'b0;
              end
            end
          end
          default: begin
            state   <= ST_IDLE;
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
